knn_feed_ctrl: RTL

KNN_FEED_CTRL -- requirements
Module: knn_feed_ctrl

---
 rtl/knn_pkg.sv | 23 ++
 rtl/knn_point_ram.sv | 34 +++
 rtl/knn_feed_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared defaults and FSM encoding for the KNN feed controller.
//   KNN_DN        points per cloud (power of two)
//   KNN_ADDR_W    packed x+y+z coordinate width
//   KNN_STAGE_NUM number of sampling stages
//   DN_WIDTH      point index width
//   STAGE_WIDTH   stage index width
//   knn_state_e   controller FSM states
package knn_pkg;

    localparam int unsigned KNN_DN        = 1024;
    localparam int unsigned KNN_ADDR_W    = 24;
    localparam int unsigned KNN_STAGE_NUM = 8;
    localparam int unsigned DN_WIDTH      = $clog2(KNN_DN);
    localparam int unsigned STAGE_WIDTH   = $clog2(KNN_STAGE_NUM);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_CP  = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_FIN = 2'd3
    } knn_state_e;

endpackage : knn_pkg

// File: rtl/knn_point_ram.sv
// knn_point_ram: DEPTH x WIDTH point store, one write port, one synchronous
// read port (one cycle latency, read-before-write on address collision).
//   clk       clock
//   i_wr_en   write enable
//   i_wr_addr write index
//   i_wr_data write data
//   i_rd_addr read index, sampled every rising edge
//   o_rd_data data at the index sampled on the previous edge
module knn_point_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage and registered read; contents are not reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule : knn_point_ram

// File: rtl/knn_feed_ctrl.sv
// knn_feed_ctrl: feeds one KNN center-point job to a downstream engine.
// Sends the center point, then streams list points one per cycle while
// issuing a per-stage sampling mask, advancing stage on output_flag and
// finishing on KNN_CP_finish.
//   clk, rst_n                      clock, async active-low reset
//   pt_wr_en/addr/data              point RAM write
//   msk_wr_en/stage/data            mask table write
//   start, cp_idx                   launch a job centered on RAM[cp_idx]
//   busy, done                      job active, one-cycle completion pulse
//   CP/CP_vld/CP_ready              center point handshake
//   LP/LP_vld/LP_ready              list point stream handshake
//   mask/mask_vld/mask_ready        per-stage mask handshake
//   output_flag, KNN_CP_finish      downstream stage-done / job-done pulses
//   stall_cnt                       (KNN_FEED_PERF_EN only) LP stall cycles
module knn_feed_ctrl
    import knn_pkg::*;
#(
    parameter int unsigned DN        = KNN_DN,
    parameter int unsigned addr_W    = KNN_ADDR_W,
    parameter int unsigned stage_num = KNN_STAGE_NUM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pt_wr_en,
    input  logic [$clog2(DN)-1:0]        pt_wr_addr,
    input  logic [addr_W-1:0]            pt_wr_data,
    input  logic                         msk_wr_en,
    input  logic [$clog2(stage_num)-1:0] msk_wr_stage,
    input  logic [DN-1:0]                msk_wr_data,
    input  logic                         start,
    input  logic [$clog2(DN)-1:0]        cp_idx,
    output logic                         busy,
    output logic                         done,
    output logic [addr_W-1:0]            CP,
    output logic                         CP_vld,
    input  logic                         CP_ready,
    output logic [addr_W-1:0]            LP,
    output logic                         LP_vld,
    input  logic                         LP_ready,
    output logic [DN-1:0]                mask,
    output logic                         mask_vld,
    input  logic                         mask_ready,
    input  logic                         output_flag,
    input  logic                         KNN_CP_finish
`ifdef KNN_FEED_PERF_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int unsigned DN_W = $clog2(DN);
    localparam int unsigned ST_W = $clog2(stage_num);
    localparam logic [ST_W-1:0] LAST_STAGE = ST_W'(stage_num - 1);

    knn_state_e r_state, w_state_nxt;

    logic [DN_W-1:0]   r_cp_idx,   w_cp_idx_nxt;
    logic [DN_W-1:0]   r_lp_cnt,   w_lp_cnt_nxt;
    logic [ST_W-1:0]   r_stage,    w_stage_nxt;
    logic [addr_W-1:0] r_cp,       w_cp_nxt;
    logic [addr_W-1:0] r_lp,       w_lp_nxt;
    logic              r_cp_vld,   w_cp_vld_nxt;
    logic              r_lp_vld,   w_lp_vld_nxt;
    logic              r_mask_vld, w_mask_vld_nxt;
    logic [DN-1:0]     r_mask,     w_mask_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;

    logic [addr_W-1:0] r_pt0;
    logic [DN-1:0]     r_tbl [stage_num];

    logic [DN_W-1:0]   w_rd_addr;
    logic [addr_W-1:0] w_rd_data;
    logic              w_cp_xfer;
    logic              w_lp_xfer;
    logic              w_mask_xfer;
    logic [ST_W-1:0]   w_stage_inc;
    logic [ST_W-1:0]   w_mask_sel;
    logic [DN-1:0]     w_mask_load;

    // Table entry with every point index at or above DN>>stage cleared
    function automatic logic [DN-1:0] f_stage_mask(input logic [DN-1:0] tbl,
                                                   input logic [ST_W-1:0] s);
        f_stage_mask = tbl & ~({DN{1'b1}} << (DN >> s));
    endfunction

    knn_point_ram #(
        .DEPTH (DN),
        .WIDTH (addr_W)
    ) u_point_ram (
        .clk       (clk),
        .i_wr_en   (pt_wr_en),
        .i_wr_addr (pt_wr_addr),
        .i_wr_data (pt_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Mask table storage; contents are not reset
    always_ff @(posedge clk) begin
        if (msk_wr_en) begin
            r_tbl[msk_wr_stage] <= msk_wr_data;
        end
    end

    // Shadow of point 0: every stage restarts at index 0 with no bubble,
    // while the RAM read port is already busy fetching point 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt0 <= '0;
        end else if (pt_wr_en && (pt_wr_addr == '0)) begin
            r_pt0 <= pt_wr_data;
        end
    end

    assign w_cp_xfer   = r_cp_vld && CP_ready;
    assign w_lp_xfer   = r_lp_vld && LP_ready;
    assign w_mask_xfer = r_mask_vld && mask_ready;
    assign w_stage_inc = r_stage + ST_W'(1);
    assign w_mask_sel  = (r_state == ST_RUN) ? w_stage_inc : '0;
    assign w_mask_load = f_stage_mask(r_tbl[w_mask_sel], w_mask_sel);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start)                                  w_state_nxt = ST_SEND_CP;
            ST_SEND_CP:  if (w_cp_xfer)                              w_state_nxt = ST_RUN;
            ST_RUN:      if (output_flag && (r_stage == LAST_STAGE)) w_state_nxt = ST_WAIT_FIN;
            ST_WAIT_FIN: if (KNN_CP_finish)                          w_state_nxt = ST_IDLE;
            default:                                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values; RAM read address always targets the
    // point that will be presented after the next LP transfer
    always_comb begin
        w_cp_idx_nxt   = r_cp_idx;
        w_lp_cnt_nxt   = r_lp_cnt;
        w_stage_nxt    = r_stage;
        w_cp_nxt       = r_cp;
        w_lp_nxt       = r_lp;
        w_cp_vld_nxt   = r_cp_vld;
        w_lp_vld_nxt   = r_lp_vld;
        w_mask_vld_nxt = r_mask_vld;
        w_mask_nxt     = r_mask;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_rd_addr      = r_lp_cnt + DN_W'(1);

        case (r_state)
            ST_IDLE: begin
                w_rd_addr = cp_idx;
                if (start) begin
                    w_cp_idx_nxt = cp_idx;
                    w_busy_nxt   = 1'b1;
                    w_stage_nxt  = '0;
                    w_lp_cnt_nxt = '0;
                    w_cp_vld_nxt = 1'b0;
                end
            end

            ST_SEND_CP: begin
                w_rd_addr = r_cp_idx;
                if (!r_cp_vld) begin
                    // RAM data for cp_idx lands this cycle; latch and hold it
                    w_cp_nxt     = w_rd_data;
                    w_cp_vld_nxt = 1'b1;
                end else if (CP_ready) begin
                    w_cp_vld_nxt   = 1'b0;
                    w_stage_nxt    = '0;
                    w_lp_cnt_nxt   = '0;
                    w_lp_nxt       = r_pt0;
                    w_lp_vld_nxt   = 1'b1;
                    w_mask_nxt     = w_mask_load;
                    w_mask_vld_nxt = 1'b1;
                    w_rd_addr      = DN_W'(1);
                end
            end

            ST_RUN: begin
                if (output_flag) begin
                    if (r_stage == LAST_STAGE) begin
                        w_lp_vld_nxt   = 1'b0;
                        w_mask_vld_nxt = 1'b0;
                    end else begin
                        w_stage_nxt    = w_stage_inc;
                        w_lp_cnt_nxt   = '0;
                        w_lp_nxt       = r_pt0;
                        w_mask_nxt     = w_mask_load;
                        w_mask_vld_nxt = 1'b1;
                        w_rd_addr      = DN_W'(1);
                    end
                end else begin
                    if (w_lp_xfer) begin
                        w_lp_nxt     = w_rd_data;
                        w_lp_cnt_nxt = r_lp_cnt + DN_W'(1);
                        w_rd_addr    = r_lp_cnt + DN_W'(2);
                    end
                    if (w_mask_xfer) begin
                        w_mask_vld_nxt = 1'b0;
                    end
                end
            end

            ST_WAIT_FIN: begin
                if (KNN_CP_finish) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end

            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cp_idx   <= '0;
            r_lp_cnt   <= '0;
            r_stage    <= '0;
            r_cp       <= '0;
            r_lp       <= '0;
            r_cp_vld   <= 1'b0;
            r_lp_vld   <= 1'b0;
            r_mask_vld <= 1'b0;
            r_mask     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cp_idx   <= w_cp_idx_nxt;
            r_lp_cnt   <= w_lp_cnt_nxt;
            r_stage    <= w_stage_nxt;
            r_cp       <= w_cp_nxt;
            r_lp       <= w_lp_nxt;
            r_cp_vld   <= w_cp_vld_nxt;
            r_lp_vld   <= w_lp_vld_nxt;
            r_mask_vld <= w_mask_vld_nxt;
            r_mask     <= w_mask_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef KNN_FEED_PERF_EN
    logic [31:0] r_stall_cnt;

    // Cycles the list-point stream is offered but not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (r_busy && r_lp_vld && !LP_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign CP       = r_cp;
    assign CP_vld   = r_cp_vld;
    assign LP       = r_lp;
    assign LP_vld   = r_lp_vld;
    assign mask     = r_mask;
    assign mask_vld = r_mask_vld;

endmodule : knn_feed_ctrl
